// File: rtl/ram_arbiter_2.sv
// Two-requester arbiter in front of a simple dual-port RAM: independent round-robin
// write and read channels, read-after-write hazard stall, 1-cycle read response.
module ram_arbiter_2 #(
  parameter int DataWidth = 8,
  parameter int AddrWidth = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             req_valid,
  input  logic [1:0]             req_write,
  input  logic [2*AddrWidth-1:0] req_addr,
  input  logic [2*DataWidth-1:0] req_data,
  output logic [1:0]             req_ready,
  output logic [1:0]             rsp_valid,
  output logic [DataWidth-1:0]   rsp_data,
  output logic                   ram_write_en,
  output logic [AddrWidth-1:0]   ram_write_addr,
  output logic [DataWidth-1:0]   ram_write_data,
  output logic                   ram_read_en,
  output logic [AddrWidth-1:0]   ram_read_addr,
  input  logic [DataWidth-1:0]   ram_read_data
);

  logic                 wr_last_q, wr_last_d;
  logic                 rd_last_q, rd_last_d;
  logic [1:0]           rsp_vld_q, rsp_vld_d;

  logic [1:0]           wr_cand, rd_cand;
  logic                 wr_idx, rd_idx;
  logic                 wr_any, rd_any, hazard;
  logic [1:0]           wr_gnt, rd_gnt;
  logic [AddrWidth-1:0] wr_addr, rd_addr;
  logic [DataWidth-1:0] wr_data;

  always_comb begin
    wr_cand = req_valid & req_write & {2{~reset}};
    rd_cand = req_valid & ~req_write & {2{~reset}};

    // With both contending, the requester not served last wins.
    wr_idx  = (wr_cand == 2'b11) ? ~wr_last_q : wr_cand[1];
    rd_idx  = (rd_cand == 2'b11) ? ~rd_last_q : rd_cand[1];

    wr_addr = wr_idx ? req_addr[AddrWidth +: AddrWidth] : req_addr[0 +: AddrWidth];
    wr_data = wr_idx ? req_data[DataWidth +: DataWidth] : req_data[0 +: DataWidth];
    rd_addr = rd_idx ? req_addr[AddrWidth +: AddrWidth] : req_addr[0 +: AddrWidth];

    wr_any  = |wr_cand;
    // A read of the address being written this cycle waits one cycle so it sees the new word.
    hazard  = wr_any && (|rd_cand) && (rd_addr == wr_addr);
    rd_any  = (|rd_cand) && !hazard;

    wr_gnt  = wr_any ? (wr_idx ? 2'b10 : 2'b01) : 2'b00;
    rd_gnt  = rd_any ? (rd_idx ? 2'b10 : 2'b01) : 2'b00;

    req_ready      = wr_gnt | rd_gnt;
    ram_write_en   = wr_any;
    ram_write_addr = wr_any ? wr_addr : '0;
    ram_write_data = wr_any ? wr_data : '0;
    ram_read_en    = rd_any;
    ram_read_addr  = rd_any ? rd_addr : '0;

    wr_last_d = wr_any ? wr_idx : wr_last_q;
    rd_last_d = rd_any ? rd_idx : rd_last_q;
    rsp_vld_d = rd_gnt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_last_q <= 1'b1;
      rd_last_q <= 1'b1;
      rsp_vld_q <= 2'b00;
    end else begin
      wr_last_q <= wr_last_d;
      rd_last_q <= rd_last_d;
      rsp_vld_q <= rsp_vld_d;
    end
  end

  // Masking with reset kills a response whose read was granted just before reset.
  always_comb begin
    rsp_valid = rsp_vld_q & {2{~reset}};
    rsp_data  = (|rsp_valid) ? ram_read_data : '0;
  end

endmodule

// File: tb/tb_ram_arbiter_2.sv
// Bench for ram_arbiter_2: behavioural RAM, reference arbiter model and a
// response scoreboard, driven by directed steps followed by random traffic.
module tb_ram_arbiter_2;
  localparam int DW = 8;
  localparam int AW = 10;

  logic            clk;
  logic            reset;
  logic [1:0]      req_valid, req_write, req_ready, rsp_valid;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_data;
  logic [DW-1:0]   rsp_data, ram_write_data, ram_read_data;
  logic            ram_write_en, ram_read_en;
  logic [AW-1:0]   ram_write_addr, ram_read_addr;

  ram_arbiter_2 #(.DataWidth(DW), .AddrWidth(AW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .ram_write_en(ram_write_en), .ram_write_addr(ram_write_addr),
    .ram_write_data(ram_write_data), .ram_read_en(ram_read_en),
    .ram_read_addr(ram_read_addr), .ram_read_data(ram_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] ram_mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (ram_write_en) ram_mem[ram_write_addr] <= ram_write_data;
    if (ram_read_en)  ram_read_data <= ram_mem[ram_read_addr];
  end

  typedef struct packed { logic idx; logic [DW-1:0] data; } rsp_t;
  rsp_t          sb_q[$];
  logic [DW-1:0] model_mem [0:(1<<AW)-1];
  logic          m_wl, m_rl;
  int            n_checks, n_fails;
  int            wr_wait [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic rst, input logic [1:0] v, input logic [1:0] w,
                      input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                      input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    logic [1:0]    wc, rc, wg, rg, ev;
    logic          wi, ri, hz;
    logic [AW-1:0] wa, ra;
    logic [DW-1:0] wd, ed;
    rsp_t          r;
    @(negedge clk);
    reset = rst; req_valid = v; req_write = w;
    req_addr = {a1, a0}; req_data = {d1, d0};
    #1;
    wc = rst ? 2'b00 : (v & w);
    rc = rst ? 2'b00 : (v & ~w);
    wi = (wc == 2'b11) ? ~m_wl : wc[1];
    ri = (rc == 2'b11) ? ~m_rl : rc[1];
    wa = wi ? a1 : a0;
    wd = wi ? d1 : d0;
    ra = ri ? a1 : a0;
    hz = (wc != 0) && (rc != 0) && (ra == wa);
    wg = (wc != 0) ? (2'b01 << wi) : 2'b00;
    rg = ((rc != 0) && !hz) ? (2'b01 << ri) : 2'b00;

    ev = 2'b00; ed = '0;
    if (rst) sb_q.delete();
    else if (sb_q.size() > 0) begin
      r = sb_q.pop_front();
      ev = 2'b01 << r.idx; ed = r.data;
    end

    chk("req_ready", 32'(req_ready), 32'(wg | rg));
    chk("ram_write_en", 32'(ram_write_en), 32'(wg != 0));
    chk("ram_write_addr", 32'(ram_write_addr), (wg != 0) ? 32'(wa) : 32'd0);
    chk("ram_write_data", 32'(ram_write_data), (wg != 0) ? 32'(wd) : 32'd0);
    chk("ram_read_en", 32'(ram_read_en), 32'(rg != 0));
    chk("ram_read_addr", 32'(ram_read_addr), (rg != 0) ? 32'(ra) : 32'd0);
    chk("rsp_valid", 32'(rsp_valid), 32'(ev));
    chk("rsp_data", 32'(rsp_data), 32'(ed));

    for (int i = 0; i < 2; i++) begin
      if (wc[i] && !req_ready[i]) wr_wait[i]++;
      else wr_wait[i] = 0;
      if (wc == 2'b11) chk("wr_starve", 32'(wr_wait[i] > 1), 32'd0);
    end

    if (rst) begin
      m_wl = 1'b1; m_rl = 1'b1;
    end else begin
      if (rg != 0) begin
        r.idx = ri; r.data = model_mem[ra];
        sb_q.push_back(r);
        m_rl = ri;
      end
      if (wg != 0) begin
        model_mem[wa] = wd;
        m_wl = wi;
      end
    end
  endtask

  initial begin
    n_checks = 0; n_fails = 0;
    wr_wait[0] = 0; wr_wait[1] = 0;
    m_wl = 1'b1; m_rl = 1'b1;
    reset = 1'b1; req_valid = 0; req_write = 0; req_addr = 0; req_data = 0;
    for (int i = 0; i < (1<<AW); i++) begin
      ram_mem[i]   = DW'(i * 3 + 1);
      model_mem[i] = DW'(i * 3 + 1);
    end

    // reset, then both write continuously: grants alternate, requester 0 first
    step(1, 2'b11, 2'b11, 10'd5, 10'd6, 8'hAA, 8'hBB);
    step(1, 2'b11, 2'b11, 10'd5, 10'd6, 8'hAA, 8'hBB);
    step(0, 2'b11, 2'b11, 10'd5, 10'd6, 8'hAA, 8'hBB);
    chk("first_wr_addr", 32'(ram_write_addr), 32'd5);
    chk("first_wr_data", 32'(ram_write_data), 32'hAA);
    for (int k = 0; k < 4; k++) step(0, 2'b11, 2'b11, 10'd5, 10'd6, 8'hAA, 8'hBB);

    // concurrent write (req 0) and read (req 1) on different addresses
    step(0, 2'b11, 2'b01, 10'd3, 10'd7, 8'h5C, 8'h00);
    step(0, 2'b00, 2'b00, 10'd0, 10'd0, 8'h00, 8'h00);

    // same-address hazard: read stalls, then returns the new word
    step(0, 2'b11, 2'b01, 10'd9, 10'd9, 8'h77, 8'h00);
    step(0, 2'b10, 2'b00, 10'd0, 10'd9, 8'h00, 8'h00);
    step(0, 2'b00, 2'b00, 10'd0, 10'd0, 8'h00, 8'h00);

    // both read continuously
    for (int k = 0; k < 6; k++) step(0, 2'b11, 2'b00, 10'd1, 10'd2, 8'h00, 8'h00);
    step(0, 2'b00, 2'b00, 10'd0, 10'd0, 8'h00, 8'h00);

    // read granted, then reset: response suppressed, pointers restored
    step(0, 2'b01, 2'b00, 10'd4, 10'd0, 8'h00, 8'h00);
    step(1, 2'b11, 2'b00, 10'd4, 10'd8, 8'h00, 8'h00);
    step(1, 2'b11, 2'b11, 10'd4, 10'd8, 8'h11, 8'h22);
    step(0, 2'b11, 2'b11, 10'd4, 10'd8, 8'h11, 8'h22);
    chk("post_reset_winner", 32'(req_ready), 32'd1);
    step(0, 2'b11, 2'b00, 10'd4, 10'd8, 8'h00, 8'h00);
    chk("post_reset_rd_winner", 32'(req_ready), 32'd1);

    // random traffic on a narrow address range to provoke hazards
    for (int k = 0; k < 10000; k++) begin
      step(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0,
           2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
           AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
           DW'($urandom), DW'($urandom));
    end
    step(0, 2'b00, 2'b00, 10'd0, 10'd0, 8'h00, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/ram_arbiter_2.md
RAM_ARBITER_2 -- requirements
Module: ram_arbiter_2

Interface
REQ-001 DataWidth, default 8, word width in bits; SHALL match attached RAM.
REQ-002 AddrWidth, default 10, address width in bits; SHALL match attached RAM.
REQ-003 clk  in  1  single clock; all state SHALL update on posedge clk.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 req_valid  in  2  per-requester request valid, bit i = requester i.
REQ-006 req_write  in  2  per-requester op: 1 = write, 0 = read.
REQ-007 req_addr  in  2*AddrWidth  requester i address in bits [i*AddrWidth +: AddrWidth].
REQ-008 req_data  in  2*DataWidth  requester i write data in bits [i*DataWidth +: DataWidth].
REQ-009 req_ready  out  2  per-requester grant; transfer occurs when req_valid[i] & req_ready[i].
REQ-010 rsp_valid  out  2  one-hot read-response strobe, bit i = requester i.
REQ-011 rsp_data  out  DataWidth  read data, valid while any rsp_valid bit is high.
REQ-012 ram_write_en / ram_write_addr / ram_write_data  out  1 / AddrWidth / DataWidth  RAM write port.
REQ-013 ram_read_en / ram_read_addr  out  1 / AddrWidth  RAM read port.
REQ-014 ram_read_data  in  DataWidth  RAM registered read output, valid 1 cycle after ram_read_en.

Function
REQ-015 Write and read channels SHALL be arbitrated independently; at most one write grant and one read grant per cycle.
REQ-016 Write candidates: req_valid[i] & req_write[i]; read candidates: req_valid[i] & ~req_write[i].
REQ-017 Single candidate on a channel SHALL be granted the same cycle (req_ready combinational, zero bubble).
REQ-018 Two candidates on a channel: grant SHALL go to the requester not granted last on that channel (round-robin), using pointers wr_last and rd_last.
REQ-019 wr_last/rd_last SHALL update to the granted index on posedge only when that channel grants; otherwise hold.
REQ-020 ram_write_en SHALL equal OR of write grants; ram_write_addr/data SHALL mux from granted requester; 0 when no grant.
REQ-021 ram_read_en SHALL equal OR of read grants; ram_read_addr SHALL mux from granted requester; 0 when no grant.
REQ-022 Hazard: if the read candidate address equals the write address granted in the same cycle, the read SHALL NOT be granted (req_ready low, rd_last held); it retries next cycle.
REQ-023 Read latency SHALL be exactly 1 cycle: rsp_valid[i] high in cycle N+1 for a read granted to i in cycle N, rsp_data = ram_read_data.
REQ-024 rsp_valid SHALL be high for exactly one cycle per granted read; responses are not back-pressured.
REQ-025 rsp_valid SHALL be 0 and rsp_data SHALL be 0 in cycles with no response.
REQ-026 Requester holding req_valid without ready SHALL see no state change and no RAM access for that request.
REQ-027 Under continuous contention each requester SHALL be granted at least once every 2 cycles per channel (no starvation), hazard stalls excepted.

Reset
REQ-028 While reset is high: req_ready = 0, ram_write_en = 0, ram_read_en = 0, RAM address/data outputs = 0.
REQ-029 On reset: wr_last = rd_last = 1 (requester 0 wins first contention), response pipeline cleared.
REQ-030 A read granted in the cycle before reset asserts SHALL NOT produce rsp_valid in the reset cycle or after.
REQ-031 First grant SHALL be possible in the first cycle after reset deasserts.

Verification
REQ-032 After reset, both requesters write (addr 5/data 0xAA, addr 6/data 0xBB) continuously -> req_ready alternates 01,10,01...; first RAM write addr 5 data 0xAA.
REQ-033 Requester 0 writes addr 3 data 0x5C while requester 1 reads addr 7 -> both granted same cycle; rsp_valid = 10 next cycle with stored word of addr 7.
REQ-034 Requester 0 writes addr 9, requester 1 reads addr 9 same cycle -> read ready = 0; read granted next cycle; response one cycle later = new write value.
REQ-035 Both read continuously, addrs 1 and 2 -> ram_read_addr alternates 1,2,1,...; rsp_valid alternates 01,10 one cycle delayed, data matches RAM model.
REQ-036 Read granted in cycle N, reset high in cycle N+1 -> rsp_valid = 00 in N+1; all ready/en = 0 while reset; requester 0 wins first contention after release.
REQ-037 Random valid/write/addr traffic 10k cycles against RAM model -> every granted read returns model data, no starvation beyond REQ-027.
